// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues sequential reads to a variable-latency ROM
// and presents buffered {pc, inst} pairs to decode, with stall and redirect/flush.
module inst_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_memReq,
  output logic [ADDR_WIDTH-1:0] o_memAddr,
  input  logic                  i_memAck,
  input  logic [INST_WIDTH-1:0] i_memInst,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirectPc,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [1:0]            dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a transfer happens on any cycle with o_memReq=1 and i_memAck=1;
  // once raised, o_memReq/o_memAddr hold until that transfer, even across redirects.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, fetch_pc_eff;
  logic [ADDR_WIDTH-1:0] redirect_pc, seq_pc, next_pc, addr_d;
  logic                  req_d;
  logic                  xfer, push, pop, room;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];

  always_comb begin
    xfer         = o_memReq && i_memAck;
    push         = (state_q == WAIT) && xfer && !i_redirect;
    pop          = (count_q != '0) && !i_stall && !i_redirect;
    count_d      = i_redirect ? '0 : (count_q + CW'(push) - CW'(pop));
    // Space is reserved before a request goes out, so a push can never overflow.
    room         = count_d < CW'(DEPTH);
    redirect_pc  = i_redirectPc & ~ADDR_WIDTH'(3);
    fetch_pc_eff = i_redirect ? redirect_pc : fetch_pc_q;
    seq_pc       = o_memAddr + ADDR_WIDTH'(4);
    next_pc      = i_redirect ? redirect_pc : seq_pc;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = o_memReq;
    addr_d     = o_memAddr;
    fetch_pc_d = fetch_pc_eff;
    case (state_q)
      IDLE: begin
        if (room) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = fetch_pc_eff;
        end
      end
      WAIT: begin
        if (xfer) begin
          fetch_pc_d = next_pc;
          if (room) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = next_pc;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (i_redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The in-flight data belongs to the flushed path; restart at the latest target.
        if (xfer) begin
          if (room) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = fetch_pc_eff;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      o_memReq   <= 1'b0;
      o_memAddr  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      o_memReq   <= req_d;
      o_memAddr  <= addr_d;
      if (i_redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[wr_ptr_q]   <= o_memAddr;
      inst_mem[wr_ptr_q] <= i_memInst;
    end
  end

  assign o_valid   = (count_q != '0);
  assign o_pc      = o_valid ? pc_mem[rd_ptr_q] : '0;
  assign o_inst    = o_valid ? inst_mem[rd_ptr_q] : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] ROM_KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        o_memReq, i_memAck = 1'b0;
  logic [31:0] o_memAddr, i_memInst = '0;
  logic        i_stall = 1'b0, i_redirect = 1'b0;
  logic [31:0] i_redirectPc = '0;
  logic        o_valid;
  logic [31:0] o_pc, o_inst;
  logic [1:0]  dbg_state;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, inst2, pc2, oinst2;
  logic [1:0]  dbg_state2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  inst_fetch_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .o_memReq(o_memReq), .o_memAddr(o_memAddr),
    .i_memAck(i_memAck), .i_memInst(i_memInst), .i_stall(i_stall),
    .i_redirect(i_redirect), .i_redirectPc(i_redirectPc), .o_valid(o_valid),
    .o_pc(o_pc), .o_inst(o_inst), .dbg_state(dbg_state)
  );

  inst_fetch_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .o_memReq(req2), .o_memAddr(addr2),
    .i_memAck(ack2), .i_memInst(inst2), .i_stall(1'b0),
    .i_redirect(1'b0), .i_redirectPc(32'h0), .o_valid(valid2),
    .o_pc(pc2), .o_inst(oinst2), .dbg_state(dbg_state2)
  );

  // zero-wait ROM for the wrap-around instance
  assign ack2  = req2;
  assign inst2 = addr2 ^ ROM_KEY;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ROM responder with programmable wait cycles; stray_ack injects a meaningless ack.
  int  rom_lat = 0;
  int  wait_cnt = 0;
  bit  stray_ack = 1'b0;
  logic req_n = 1'b0, ack_n = 1'b0;

  always @(negedge clk) begin
    req_n = o_memReq;
    ack_n = i_memAck;
  end

  always @(posedge clk) begin
    #2;
    if (!req_n || ack_n) wait_cnt = 0;
    else wait_cnt++;
    i_memAck  = (o_memReq && wait_cnt >= rom_lat) || stray_ack;
    i_memInst = o_memAddr ^ ROM_KEY;
  end

  // reference model: expected FIFO contents plus one outstanding-request record
  logic [63:0] exp_q[$];
  logic        m_req = 1'b0;
  logic        m_drop = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_fetch = 32'h0;

  always @(posedge clk) begin
    logic [31:0] tgt;
    logic        xf;
    logic        popping;
    if (!rst) begin
      exp_q.delete();
      m_req = 1'b0; m_drop = 1'b0; m_addr = 32'h0; m_fetch = 32'h0;
    end else begin
      tgt     = i_redirectPc & 32'hFFFF_FFFC;
      xf      = m_req && i_memAck;
      popping = (exp_q.size() != 0) && !i_stall && !i_redirect;
      if (i_redirect) exp_q.delete();
      else begin
        if (popping) void'(exp_q.pop_front());
        if (xf && !m_drop) exp_q.push_back({m_addr, i_memInst});
      end
      if (xf) begin
        if (i_redirect)  m_fetch = tgt;
        else if (!m_drop) m_fetch = m_addr + 32'd4;
        m_drop = 1'b0;
        m_req  = 1'b0;
      end else if (i_redirect) begin
        m_fetch = tgt;
        if (m_req) m_drop = 1'b1;
      end
      if (!m_req && exp_q.size() < DEPTH) begin
        m_req  = 1'b1;
        m_addr = m_fetch;
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", o_valid, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("pc", o_pc, exp_q[0][63:32]);
        check("inst", o_inst, exp_q[0][31:0]);
      end else begin
        check("inst_nop", o_inst, 32'h0);
      end
      check("mem_req", o_memReq, m_req);
      check("mem_addr", o_memAddr, m_addr);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [31:0] a, input string nm);
    int n = 0;
    while (!(o_memReq && o_memAddr == a) && n < 200) begin
      tick();
      n++;
    end
    check(nm, (n < 200), 1);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!o_valid && n < 200) begin
      tick();
      n++;
    end
    check(nm, (n < 200), 1);
  endtask

  logic [31:0] acked_addr;
  logic [31:0] a0;
  logic [23:0] stall_pat;

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    tick();

    // reset release with zero-wait ROM
    rst = 1'b1;
    tick();
    check("e1_req", o_memReq, 1);
    check("e1_addr", o_memAddr, 32'h0);
    check("e1_valid", o_valid, 0);
    tick();
    check("e2_valid", o_valid, 1);
    check("e2_pc", o_pc, 32'h0);
    check("e2_inst", o_inst, 32'hA5A5_A5A5);
    check("e2_addr", o_memAddr, 32'h4);
    check("wrap_pc0", pc2, 32'hFFFF_FFF8);
    check("wrap_inst0", oinst2, 32'h5A5A_5A5D);
    tick();
    check("e3_pc", o_pc, 32'h4);
    check("wrap_pc1", pc2, 32'hFFFF_FFFC);
    tick();
    check("e4_pc", o_pc, 32'h8);
    check("wrap_pc2", pc2, 32'h0);
    tick();
    check("e5_pc", o_pc, 32'hC);
    check("wrap_pc3", pc2, 32'h4);

    // stall until full, then release
    i_stall = 1'b1;
    repeat (10) tick();
    check("full_req", o_memReq, 0);
    check("full_valid", o_valid, 1);
    check("full_head", o_pc, 32'hC);
    i_stall = 1'b0;
    tick();
    check("rel_pc0", o_pc, 32'h10);
    tick();
    check("rel_pc1", o_pc, 32'h14);
    tick();
    check("rel_pc2", o_pc, 32'h18);
    tick();
    check("rel_pc3", o_pc, 32'h1C);

    // redirect while a slow request is outstanding
    rom_lat = 3;
    wait_addr(32'h40, "wait_req_40");
    tick();
    i_redirect = 1'b1;
    i_redirectPc = 32'h100;
    tick();
    i_redirect = 1'b0;
    check("drop_req", o_memReq, 1);
    check("drop_addr", o_memAddr, 32'h40);
    check("drop_valid", o_valid, 0);
    wait_addr(32'h100, "wait_req_100");
    wait_valid("wait_valid_100");
    check("flush_pc", o_pc, 32'h100);
    check("flush_inst", o_inst, 32'h100 ^ ROM_KEY);

    // redirect coinciding with an ack and a pop
    rom_lat = 0;
    repeat (6) tick();
    check("pre_redir_valid", o_valid, 1);
    acked_addr = o_memAddr;
    i_redirect = 1'b1;
    i_redirectPc = 32'h41;
    tick();
    i_redirect = 1'b0;
    check("redir_empty", o_valid, 0);
    check("redir_req", o_memReq, 1);
    check("redir_addr", o_memAddr, 32'h40);
    tick();
    check("redir_pc", o_pc, 32'h40);
    check("redir_inst", o_inst, 32'h40 ^ ROM_KEY);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_stale_entry", (o_valid && o_pc == acked_addr), 0);
    end

    // reset during a slow request, with a stray ack on the reset cycle
    rom_lat = 5;
    a0 = o_memAddr;
    begin
      int n = 0;
      while (o_memAddr == a0 && n < 50) begin
        tick();
        n++;
      end
      check("wait_new_req", (n < 50), 1);
    end
    tick();
    tick();
    rst = 1'b0;
    stray_ack = 1'b1;
    tick();
    check("rst_req", o_memReq, 0);
    check("rst_valid", o_valid, 0);
    check("rst_inst", o_inst, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_addr", o_memAddr, 32'h0);
    check("rst_addr2", addr2, 32'hFFFF_FFF8);
    rst = 1'b1;
    stray_ack = 1'b0;
    tick();
    check("post_rst_req", o_memReq, 1);
    check("post_rst_addr", o_memAddr, 32'h0);
    wait_valid("wait_valid_rst");
    check("post_rst_pc", o_pc, 32'h0);
    check("post_rst_inst", o_inst, ROM_KEY);

    // mixed stall pattern with one-wait ROM
    rom_lat = 1;
    stall_pat = 24'b1110_0101_1111_1000_1101_0011;
    for (int i = 0; i < 24; i++) begin
      i_stall = stall_pat[i];
      tick();
    end
    i_stall = 1'b0;
    repeat (10) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
